multicycle_sequencer: RTL and testbench

Multi-cycle FSM that sequences the 8-bit RISC datapath through the fetch, decode, execute, memory and writeback phases for each instruction. It owns the PC and instruction register and drives the instruction-memory handshake and the data-memory handshake. It asserts the register-write and ALU-op controls in the correct phase. It sits between the instruction/data memories and the register file/ALU, one instruction in flight at a time.

---
 rtl/multicycle_sequencer_pkg.sv | 41 ++++
 rtl/seq_opclass_decode.sv | 43 ++++
 rtl/multicycle_sequencer.sv | 133 +++++++++++++
 tb/tb_multicycle_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_sequencer_pkg.sv
// Shared definitions for the multi-cycle instruction sequencer: opcode
// encodings, ALU operation encodings, FSM state type and the decoded
// opcode-class record.
// Ports: none (package).
package multicycle_sequencer_pkg;

   // Opcode occupies the top OPC_W bits of the instruction word;
   // the operand occupies the low OPERAND_W bits.
   localparam int OPC_W     = 4;
   localparam int OPERAND_W = 4;

   localparam logic [OPC_W-1:0] OP_NOP   = 4'h0;
   localparam logic [OPC_W-1:0] OP_ADD   = 4'h1;
   localparam logic [OPC_W-1:0] OP_SUB   = 4'h2;
   localparam logic [OPC_W-1:0] OP_LOAD  = 4'h3;
   localparam logic [OPC_W-1:0] OP_STORE = 4'h4;
   localparam logic [OPC_W-1:0] OP_JUMP  = 4'h5;
   localparam logic [OPC_W-1:0] OP_HALT  = 4'hF;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECODE,
      EXEC,
      MEM,
      WB,
      HALTED
   } seq_state_t;

   typedef struct packed {
      logic is_alu;
      logic is_load;
      logic is_store;
      logic is_jump;
      logic is_halt;
   } op_class_t;

endpackage

// File: rtl/seq_opclass_decode.sv
// Combinational opcode classifier used while the sequencer is in DECODE.
// Ports:
//   opcode   - opcode field of the instruction register
//   is_alu   - ADD or SUB
//   is_load  - LOAD (immediate, no memory access)
//   is_store - STORE
//   is_jump  - JUMP
//   is_halt  - HALT
//   alu_op   - ALU operation (SUB -> 01, everything else -> 00)
module seq_opclass_decode
   import multicycle_sequencer_pkg::*;
(
   input  logic [OPC_W-1:0] opcode,
   output logic             is_alu,
   output logic             is_load,
   output logic             is_store,
   output logic             is_jump,
   output logic             is_halt,
   output logic [1:0]       alu_op
);

   always_comb begin
      is_alu   = 1'b0;
      is_load  = 1'b0;
      is_store = 1'b0;
      is_jump  = 1'b0;
      is_halt  = 1'b0;
      alu_op   = ALU_ADD;
      case (opcode)
         OP_ADD:   is_alu = 1'b1;
         OP_SUB: begin
            is_alu = 1'b1;
            alu_op = ALU_SUB;
         end
         OP_LOAD:  is_load  = 1'b1;
         OP_STORE: is_store = 1'b1;
         OP_JUMP:  is_jump  = 1'b1;
         OP_HALT:  is_halt  = 1'b1;
         default:  ;  // NOP and unassigned opcodes
      endcase
   end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle sequencer for the 8-bit RISC datapath. Owns PC and
// instruction register, drives the instruction/data memory handshakes and
// the register-write / ALU-op controls, and counts retired instructions.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   run                   - enable, sampled in IDLE and at instruction boundaries
//   imem_req/addr         - fetch request and address (= pc)
//   imem_rdata/valid      - fetched instruction and its valid strobe
//   dmem_req/we, ready    - STORE data access and its acceptance
//   pc, instr             - program counter, instruction register
//   alu_op, reg_write     - ALU operation, write-back pulse
//   halted, retired       - halted flag, saturating retired count
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for run
// FETCH  | imem_req held until imem_valid; captures instr, pc += 1
// DECODE | classifies opcode, registers alu_op
// EXEC   | JUMP loads pc; routes to MEM / WB / HALTED / boundary
// MEM    | STORE write held until dmem_ready, then boundary
// WB     | one-cycle reg_write, then boundary
// HALTED | parked until reset
module multicycle_sequencer
   import multicycle_sequencer_pkg::*;
#(
   parameter int PC_W    = 8,
   parameter int INSTR_W = 8,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               run,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               imem_valid,
   output logic               dmem_req,
   output logic               dmem_we,
   input  logic               dmem_ready,
   output logic [PC_W-1:0]    pc,
   output logic [INSTR_W-1:0] instr,
   output logic [1:0]         alu_op,
   output logic               reg_write,
   output logic               halted,
   output logic [CNT_W-1:0]   retired
);

   seq_state_t state, state_nxt;
   op_class_t  cls_q, cls_d;
   logic [1:0] alu_op_d;
   logic       boundary;

   seq_opclass_decode u_decode (
      .opcode   (instr[INSTR_W-1 -: OPC_W]),
      .is_alu   (cls_d.is_alu),
      .is_load  (cls_d.is_load),
      .is_store (cls_d.is_store),
      .is_jump  (cls_d.is_jump),
      .is_halt  (cls_d.is_halt),
      .alu_op   (alu_op_d)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      boundary  = 1'b0;
      case (state)
         IDLE:   if (run) state_nxt = FETCH;
         FETCH:  if (imem_valid) state_nxt = DECODE;
         DECODE: state_nxt = EXEC;
         EXEC: begin
            if (cls_q.is_halt)                      state_nxt = HALTED;
            else if (cls_q.is_store)                state_nxt = MEM;
            else if (cls_q.is_alu || cls_q.is_load) state_nxt = WB;
            else                                    boundary  = 1'b1;
         end
         MEM:    if (dmem_ready) boundary = 1'b1;
         WB:     boundary = 1'b1;
         HALTED: state_nxt = HALTED;
         default: state_nxt = IDLE;
      endcase
      if (boundary) state_nxt = run ? FETCH : IDLE;
   end

   always_comb begin
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      reg_write = 1'b0;
      halted    = 1'b0;
      case (state)
         FETCH:  imem_req = 1'b1;
         MEM: begin
            dmem_req = 1'b1;
            dmem_we  = 1'b1;
         end
         WB:     reg_write = 1'b1;
         HALTED: halted    = 1'b1;
         default: ;
      endcase
   end

   assign imem_addr = pc;

   always_ff @(posedge clk) begin
      if (reset) begin
         pc      <= '0;
         instr   <= '0;
         alu_op  <= ALU_ADD;
         cls_q   <= '0;
         retired <= '0;
      end else begin
         if (state == FETCH && imem_valid) begin
            instr <= imem_rdata;
            pc    <= pc + 1'b1;
         end
         if (state == DECODE) begin
            alu_op <= alu_op_d;
            cls_q  <= cls_d;
         end
         // JUMP target replaces the increment already applied in FETCH.
         if (state == EXEC && cls_q.is_jump)
            pc <= PC_W'(instr[OPERAND_W-1:0]);
         if (boundary && retired != '1)
            retired <= retired + 1'b1;
      end
   end

endmodule

// File: tb/tb_multicycle_sequencer.sv
module tb_multicycle_sequencer;

   logic        clk;
   logic        reset, run;
   logic        imem_req, imem_valid;
   logic [7:0]  imem_addr, imem_rdata;
   logic        dmem_req, dmem_we, dmem_ready;
   logic [7:0]  pc, instr;
   logic [1:0]  alu_op;
   logic        reg_write, halted;
   logic [15:0] retired;

   multicycle_sequencer #(.PC_W(8), .INSTR_W(8), .CNT_W(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .run        (run),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .imem_valid (imem_valid),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_ready (dmem_ready),
      .pc         (pc),
      .instr      (instr),
      .alu_op     (alu_op),
      .reg_write  (reg_write),
      .halted     (halted),
      .retired    (retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] imem [256];
   int imem_wait, dmem_wait, i_cnt, d_cnt;
   bit noise;
   int n_checks, n_errors;

   typedef struct {
      logic [7:0] op;
      int iw;
      int dw;
      int e_cyc;
      int e_rw;
      int e_dm;
      int e_alu;
      int e_pc;
   } vec_t;
   vec_t vecs[9];

   // Memory responder: drives inputs at the falling edge. imem_valid comes
   // after imem_wait request cycles, dmem_ready after dmem_wait; outside a
   // request the strobes carry random noise when enabled.
   initial begin
      imem_valid = 1'b0; imem_rdata = '0; dmem_ready = 1'b0;
      i_cnt = 0; d_cnt = 0;
      forever begin
         @(negedge clk);
         if (imem_req) begin
            imem_valid = (i_cnt == imem_wait);
            imem_rdata = imem_valid ? imem[imem_addr] : 8'($urandom);
            i_cnt      = imem_valid ? 0 : i_cnt + 1;
         end else begin
            imem_valid = noise ? 1'($urandom) : 1'b0;
            imem_rdata = 8'($urandom);
            i_cnt      = 0;
         end
         if (dmem_req) begin
            dmem_ready = (d_cnt == dmem_wait);
            d_cnt      = dmem_ready ? 0 : d_cnt + 1;
         end else begin
            dmem_ready = noise ? 1'($urandom) : 1'b0;
            d_cnt      = 0;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
   endtask

   // Called at the first FETCH cycle of an instruction; returns when the
   // next instruction's FETCH begins.
   task automatic measure(output int cyc, output int rw, output int dm, output int alu);
      bit left;
      cyc = 0; rw = 0; dm = 0; alu = 0; left = 0;
      while (cyc < 200) begin
         if (!imem_req) left = 1;
         else if (left) break;
         if (reg_write) begin
            rw++;
            alu = int'(alu_op);
         end
         if (dmem_req && dmem_we) dm++;
         cyc++;
         step();
      end
      if (cyc >= 200) begin
         n_checks++;
         n_errors++;
         $display("FAIL measure_timeout: got %0d cycles expected next fetch", cyc);
      end
   endtask

   initial begin
      int cyc, rw, dm, alu, n, bad, m_pc, m_ret, iw, dw, e_cyc;
      logic [7:0] b;
      logic [3:0] op;
      bit wb, st, jp;

      n_checks = 0; n_errors = 0;
      reset = 1'b1; run = 1'b0; noise = 0;
      imem_wait = 0; dmem_wait = 0;
      for (int a = 0; a < 256; a++) imem[a] = 8'h00;

      // Reset state
      do_reset();
      chk("rst_pc", 32'(pc), 0);
      chk("rst_instr", 32'(instr), 0);
      chk("rst_alu_op", 32'(alu_op), 0);
      chk("rst_retired", 32'(retired), 0);
      chk("rst_strobes", 32'({imem_req, dmem_req, dmem_we, reg_write, halted}), 0);
      reset = 1'b0;
      bad = 0;
      repeat (4) begin
         step();
         if (imem_req) bad++;
      end
      chk("idle_no_req", 32'(bad), 0);

      // Single-instruction vectors from reset
      vecs[0] = '{8'h1A, 0, 0, 4, 1, 0, 0, 1};
      vecs[1] = '{8'h23, 3, 0, 7, 1, 0, 1, 1};
      vecs[2] = '{8'h45, 0, 2, 6, 0, 3, 0, 1};
      vecs[3] = '{8'h57, 0, 0, 3, 0, 0, 0, 7};
      vecs[4] = '{8'h3C, 1, 0, 5, 1, 0, 0, 1};
      vecs[5] = '{8'h9F, 2, 0, 5, 0, 0, 0, 1};
      vecs[6] = '{8'h4C, 0, 0, 4, 0, 1, 0, 1};
      vecs[7] = '{8'hE0, 0, 0, 3, 0, 0, 0, 1};
      vecs[8] = '{8'h00, 0, 0, 3, 0, 0, 0, 1};
      for (int i = 0; i < 9; i++) begin
         imem[0]   = vecs[i].op;
         imem_wait = vecs[i].iw;
         dmem_wait = vecs[i].dw;
         run = 1'b1;
         do_reset();
         reset = 1'b0;
         step();
         chk($sformatf("v%0d_first_req", i), 32'(imem_req), 1);
         chk($sformatf("v%0d_fetch_addr", i), 32'(imem_addr), 0);
         measure(cyc, rw, dm, alu);
         chk($sformatf("v%0d_cycles", i), 32'(cyc), vecs[i].e_cyc);
         chk($sformatf("v%0d_reg_write", i), 32'(rw), vecs[i].e_rw);
         chk($sformatf("v%0d_dmem_cycles", i), 32'(dm), vecs[i].e_dm);
         chk($sformatf("v%0d_alu_op", i), 32'(alu), vecs[i].e_alu);
         chk($sformatf("v%0d_pc", i), 32'(pc), vecs[i].e_pc);
         chk($sformatf("v%0d_retired", i), 32'(retired), 1);
      end
      imem[0] = 8'h00; imem_wait = 0; dmem_wait = 0;

      // JUMP at 0xFF: increment wraps to 0, then jump lands on 7
      imem[255] = 8'h57;
      run = 1'b1;
      do_reset();
      reset = 1'b0;
      n = 0;
      while (!(imem_req && imem_addr == 8'hFF) && n < 1000) begin
         step();
         n++;
      end
      chk("jmp_reach_ff", 32'(imem_addr), 32'hFF);
      step();
      chk("jmp_pc_wrap", 32'(pc), 0);
      chk("jmp_instr", 32'(instr), 32'h57);
      rw = int'(reg_write);
      step();
      rw += int'(reg_write);
      step();
      chk("jmp_next_req", 32'(imem_req), 1);
      chk("jmp_next_addr", 32'(imem_addr), 7);
      chk("jmp_no_reg_write", 32'(rw), 0);
      chk("jmp_retired", 32'(retired), 256);
      imem[255] = 8'h00;

      // HALT parks until reset, run ignored
      imem[0] = 8'hF0;
      do_reset();
      reset = 1'b0;
      n = 0;
      while (!halted && n < 20) begin
         step();
         n++;
      end
      chk("halt_reached", 32'(halted), 1);
      bad = 0;
      repeat (20) begin
         step();
         if (imem_req || dmem_req || !halted) bad++;
      end
      chk("halt_hold", 32'(bad), 0);
      chk("halt_retired", 32'(retired), 0);
      reset = 1'b1;
      step();
      chk("halt_rst_halted", 32'(halted), 0);
      chk("halt_rst_pc", 32'(pc), 0);
      chk("halt_rst_retired", 32'(retired), 0);
      chk("halt_rst_req", 32'(imem_req), 0);

      // Reset while MEM waits for dmem_ready
      imem[0] = 8'h45;
      dmem_wait = 100;
      do_reset();
      reset = 1'b0;
      n = 0;
      while (!dmem_req && n < 20) begin
         step();
         n++;
      end
      step();
      chk("mrst_in_mem", 32'(dmem_req), 1);
      reset = 1'b1;
      step();
      chk("mrst_dmem_req", 32'({dmem_req, dmem_we}), 0);
      chk("mrst_pc", 32'(pc), 0);
      chk("mrst_idle", 32'({imem_req, reg_write, halted}), 0);
      dmem_wait = 0;

      // run dropped during DECODE of ADD: WB completes, then IDLE
      imem[0] = 8'h1A;
      do_reset();
      reset = 1'b0;
      step();
      step();
      run = 1'b0;
      rw = 0; bad = 0;
      repeat (10) begin
         step();
         rw += int'(reg_write);
         if (imem_req) bad++;
      end
      chk("rdrop_reg_write", 32'(rw), 1);
      chk("rdrop_no_fetch", 32'(bad), 0);
      chk("rdrop_retired", 32'(retired), 1);
      chk("rdrop_pc", 32'(pc), 1);

      // Randomized program against an instruction-level model
      noise = 1;
      for (int a = 0; a < 256; a++) begin
         b = 8'($urandom);
         if (b[7:4] == 4'hF) b[7:4] = 4'h0;
         imem[a] = b;
      end
      run = 1'b1;
      do_reset();
      reset = 1'b0;
      step();
      m_pc = 0; m_ret = 0;
      for (int k = 0; k < 60; k++) begin
         iw = int'($urandom_range(0, 3));
         dw = int'($urandom_range(0, 3));
         imem_wait = iw;
         dmem_wait = dw;
         chk("rnd_addr", 32'(imem_addr), m_pc);
         b  = imem[m_pc];
         op = b[7:4];
         wb = (op == 4'h1 || op == 4'h2 || op == 4'h3);
         st = (op == 4'h4);
         jp = (op == 4'h5);
         e_cyc = iw + 3 + (wb ? 1 : 0) + (st ? dw + 1 : 0);
         m_pc  = jp ? int'(b[3:0]) : (m_pc + 1) % 256;
         m_ret++;
         measure(cyc, rw, dm, alu);
         chk("rnd_cycles", 32'(cyc), e_cyc);
         chk("rnd_reg_write", 32'(rw), wb ? 1 : 0);
         chk("rnd_dmem_cycles", 32'(dm), st ? dw + 1 : 0);
         if (wb) chk("rnd_alu_op", 32'(alu), (op == 4'h2) ? 1 : 0);
         chk("rnd_pc", 32'(pc), m_pc);
         chk("rnd_retired", 32'(retired), m_ret);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
